combat_referee: RTL and testbench
=================================

// Module: combat_referee
// PURPOSE
//  Judges hits between the two fighters once per frame, keeps health and win state.
//  Consumes each fighter's action flags (kick/fight/dodge) and positions.
//  Produces the knockback/block commands (back1/back2, stand_left/right), HP and p1win/p2win.
//  Sits directly downstream of, and feeds back into, both player motion blocks.
// PARAMETERS
//  HP_MAX       100  starting health per player (7-bit)
//  KICK_DMG      15  damage of an unblocked kick
//  PUNCH_DMG     10  damage of an unblocked punch (fight)
//  HIT_RANGE     60  max |BallX_p1 - BallX_p2| for a hit to land
//  KNOCK_FRAMES  12  frames back code 2 is held after a clean hit
//  BLOCK_FRAMES   6  frames back code 1 is held after a blocked hit
// PORTS
//  Clk                    in   1   system clock
//  Reset                  in   1   synchronous, active-high reset
//  frame_en               in   1   one-Clk strobe per video frame; all state advances only on it
//  start                  in   1   level; leaves IDLE
//  kick_p1,fight_p1,dodge_p1 in 1 each  player-1 action flags
//  kick_p2,fight_p2,dodge_p2 in 1 each  player-2 action flags
//  BallX_p1, BallX_p2     in  10   fighter X positions
//  near_y                 in   1   fighters vertically within reach
//  back1, back2           out  2   0 none, 1 block-stun, 2 knockback (per victim)
//  stand_left1,stand_right1 out 1 each  push direction for player 1 while back1!=0
//  stand_left2,stand_right2 out 1 each  push direction for player 2 while back2!=0
//  hp1, hp2               out  7   current health
//  p1win, p2win           out  1   latched result; both high = draw
// BEHAVIOUR
//  Reset: state IDLE, hp1=hp2=HP_MAX, back*=0, stand_*=0, p*win=0, timers=0, edge regs=0.
//  Nothing changes on cycles with frame_en=0; all outputs are registered, updated the Clk after frame_en.
//  FSM: IDLE -(start)-> FIGHT -(hp1==0 or hp2==0)-> OVER; OVER holds until Reset.
//   IDLE: no hits judged, hp held at HP_MAX.
//   OVER: no hits judged, back* forced to 0, timers cleared.
//  Attack start = rising edge of kick_pX|fight_pX, using the previous-frame registered value;
//   holding the key does not re-hit. Kick has priority over fight when both rise together.
//  Hit condition (FIGHT only): attack start AND |dX|<=HIT_RANGE AND near_y AND attacker back==0
//   AND victim back==0. A victim with back!=0 is invulnerable; that attack is lost.
//   |dX| uses an unsigned subtract of the larger minus the smaller.
//  Victim dodge_pX=1: back=1 for BLOCK_FRAMES, no damage.
//   Otherwise: back=2 for KNOCK_FRAMES, hp -= dmg, saturating at 0.
//  Push direction is latched at the hit for the whole timer:
//   victim X >= attacker X -> stand_right=1, otherwise stand_left=1. Exactly one is high while back!=0.
//  Timer: loads N on the hit and decrements each frame; back returns to 0 on the frame it reaches 0.
//   So back!=0 for exactly N frames.
//  Simultaneous attack starts by both players with both hit conditions met: both hits apply (trade).
//  Win: evaluated from the post-damage hp in the same frame as the hit.
//   hp2==0 -> p1win; hp1==0 -> p2win; both -> both high. Latched until Reset.
//  Reset mid-fight returns everything to IDLE values on the next Clk.
// STRUCTURE
//  combat_pkg: back_code_t enum {BACK_NONE=0, BACK_BLOCK=1, BACK_KNOCK=2}, game_state_t {IDLE,FIGHT,OVER},
//   default damage and frame constants.
//  Sub-module knock_timer (one instance per player).
//   Inputs: frame_en, load, code, dir. Outputs: back, stand_left, stand_right, busy.
//   4-bit down-counter.
//  Top level holds the FSM, edge registers, range compare, hit judge and HP arithmetic.
// TESTING
//  1 Reset, start=1, X1=100, X2=140, near_y=1, kick_p1 0->1 -> next frame hp2=85, back2=2 for 12 frames,
//    stand_right2=1; holding kick gives no second hit.
//  2 Same with dodge_p2=1 -> hp2 stays 100, back2=1 for 6 frames, then 0.
//  3 kick_p1 and fight_p2 rise in the same frame within range -> hp2=85, hp1=90, back1=back2=2.
//  4 X2-X1=61 or near_y=0 -> no hit; X2-X1=60 -> hit.
//    Second kick during back2=2 -> ignored; hp2 unchanged.
//  5 hp2=10, fight_p1 hit -> hp2=0, p1win=1, FSM OVER; further attacks ignored; back* forced to 0.
//  6 Reset asserted while back2=2 mid-timer -> next Clk: hp=100, back*=0, state IDLE.
//    frame_en=0 for 50 cycles -> no state change.

Source files
------------

// File: rtl/combat_pkg.sv
// Shared types and default constants for the combat referee.
//   back_code_t  : per-victim stun code driven onto back1/back2
//   game_state_t : referee match state
package combat_pkg;

  typedef enum logic [1:0] {
    BACK_NONE  = 2'd0,
    BACK_BLOCK = 2'd1,
    BACK_KNOCK = 2'd2
  } back_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    OVER  = 2'd2
  } game_state_t;

  localparam int HP_MAX_DEF       = 100;
  localparam int KICK_DMG_DEF     = 15;
  localparam int PUNCH_DMG_DEF    = 10;
  localparam int HIT_RANGE_DEF    = 60;
  localparam int KNOCK_FRAMES_DEF = 12;
  localparam int BLOCK_FRAMES_DEF = 6;

endpackage

// File: rtl/combat_referee_knock_timer.sv
// knock_timer: per-victim stun timer.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   frame_en_i         frame strobe; state only moves on it
//   clr_i              drop any running stun (match over)
//   load_i, code_i     start a stun of the given kind
//   dir_i              1 = push right, 0 = push left (latched at load)
//   back_o             current stun code, BACK_NONE when idle
//   stand_left_o/right_o  latched push direction while stunned
//   busy_o             stun active (victim invulnerable, cannot attack)
module knock_timer
  import combat_pkg::*;
#(
  parameter int KNOCK_LEN = KNOCK_FRAMES_DEF,
  parameter int BLOCK_LEN = BLOCK_FRAMES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_en_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  back_code_t code_i,
  input  logic       dir_i,
  output back_code_t back_o,
  output logic       stand_left_o,
  output logic       stand_right_o,
  output logic       busy_o
);

  logic [3:0] cnt_q;
  back_code_t code_q;
  logic       left_q, right_q;

  // The code is dropped on the same frame the count reaches zero, so the
  // stun is visible for exactly the loaded number of frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      code_q  <= BACK_NONE;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else if (frame_en_i) begin
      if (clr_i) begin
        cnt_q   <= '0;
        code_q  <= BACK_NONE;
        left_q  <= 1'b0;
        right_q <= 1'b0;
      end else if (load_i) begin
        cnt_q   <= (code_i == BACK_BLOCK) ? 4'(BLOCK_LEN) : 4'(KNOCK_LEN);
        code_q  <= code_i;
        left_q  <= ~dir_i;
        right_q <= dir_i;
      end else if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          code_q  <= BACK_NONE;
          left_q  <= 1'b0;
          right_q <= 1'b0;
        end
      end
    end
  end

  assign back_o        = code_q;
  assign stand_left_o  = left_q;
  assign stand_right_o = right_q;
  assign busy_o        = (cnt_q != 4'd0);

endmodule

// File: rtl/combat_referee.sv
// combat_referee: judges hits between two fighters once per frame and keeps
// health and win state.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   frame_en                   one-clock frame strobe; everything advances on it
//   start                      leaves IDLE
//   kick/fight/dodge_p1,_p2    action flags
//   BallX_p1, BallX_p2, near_y fighter positions / vertical reach
//   back1, back2               0 none, 1 block-stun, 2 knockback
//   stand_left/right1,2        push direction while stunned
//   hp1, hp2                   health
//   p1win, p2win               latched result (both = draw)
module combat_referee
  import combat_pkg::*;
#(
  parameter int HP_MAX       = HP_MAX_DEF,
  parameter int KICK_DMG     = KICK_DMG_DEF,
  parameter int PUNCH_DMG    = PUNCH_DMG_DEF,
  parameter int HIT_RANGE    = HIT_RANGE_DEF,
  parameter int KNOCK_FRAMES = KNOCK_FRAMES_DEF,
  parameter int BLOCK_FRAMES = BLOCK_FRAMES_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_en,
  input  logic       start,
  input  logic       kick_p1,
  input  logic       fight_p1,
  input  logic       dodge_p1,
  input  logic       kick_p2,
  input  logic       fight_p2,
  input  logic       dodge_p2,
  input  logic [9:0] BallX_p1,
  input  logic [9:0] BallX_p2,
  input  logic       near_y,
  output logic [1:0] back1,
  output logic [1:0] back2,
  output logic       stand_left1,
  output logic       stand_right1,
  output logic       stand_left2,
  output logic       stand_right2,
  output logic [6:0] hp1,
  output logic [6:0] hp2,
  output logic       p1win,
  output logic       p2win
);

  game_state_t state_q;
  logic [6:0]  hp1_q, hp2_q, hp1_d, hp2_d;
  logic        atk1_prev_q, atk2_prev_q;
  logic        p1win_q, p2win_q;

  logic        atk1, atk2, start1, start2;
  logic        busy1, busy2, hit1, hit2;
  logic [9:0]  dx;
  logic        in_range, game_over, tmr_clr;
  logic [6:0]  dmg1, dmg2;
  back_code_t  back1_c, back2_c, code1, code2;

  assign dx       = (BallX_p1 >= BallX_p2) ? (BallX_p1 - BallX_p2) : (BallX_p2 - BallX_p1);
  assign in_range = near_y && (dx <= 10'(HIT_RANGE));

  // Attack starts are edges against last frame's combined kick|fight.
  assign atk1   = kick_p1 | fight_p1;
  assign atk2   = kick_p2 | fight_p2;
  assign start1 = atk1 & ~atk1_prev_q;
  assign start2 = atk2 & ~atk2_prev_q;

  // Either fighter being stunned blocks both directions of attack, so a
  // simultaneous trade only happens when both are free.
  assign hit1 = (state_q == FIGHT) && start1 && in_range && !busy1 && !busy2;
  assign hit2 = (state_q == FIGHT) && start2 && in_range && !busy1 && !busy2;

  assign dmg1  = kick_p1 ? 7'(KICK_DMG) : 7'(PUNCH_DMG);
  assign dmg2  = kick_p2 ? 7'(KICK_DMG) : 7'(PUNCH_DMG);
  assign code1 = dodge_p1 ? BACK_BLOCK : BACK_KNOCK;
  assign code2 = dodge_p2 ? BACK_BLOCK : BACK_KNOCK;

  always_comb begin
    hp1_d = hp1_q;
    hp2_d = hp2_q;
    if (hit2 && !dodge_p1) hp1_d = (hp1_q > dmg2) ? (hp1_q - dmg2) : 7'd0;
    if (hit1 && !dodge_p2) hp2_d = (hp2_q > dmg1) ? (hp2_q - dmg1) : 7'd0;
  end

  assign game_over = (state_q == FIGHT) && ((hp1_d == 7'd0) || (hp2_d == 7'd0));
  // Stuns are dropped as the match ends so back* is already 0 in OVER.
  assign tmr_clr   = (state_q == OVER) || game_over;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      hp1_q       <= 7'(HP_MAX);
      hp2_q       <= 7'(HP_MAX);
      atk1_prev_q <= 1'b0;
      atk2_prev_q <= 1'b0;
      p1win_q     <= 1'b0;
      p2win_q     <= 1'b0;
    end else if (frame_en) begin
      atk1_prev_q <= atk1;
      atk2_prev_q <= atk2;
      case (state_q)
        IDLE: if (start) state_q <= FIGHT;
        FIGHT: begin
          hp1_q <= hp1_d;
          hp2_q <= hp2_d;
          if (game_over) begin
            state_q <= OVER;
            p1win_q <= (hp2_d == 7'd0);
            p2win_q <= (hp1_d == 7'd0);
          end
        end
        default: state_q <= OVER;
      endcase
    end
  end

  knock_timer #(.KNOCK_LEN(KNOCK_FRAMES), .BLOCK_LEN(BLOCK_FRAMES)) u_tmr1 (
    .clk_i(Clk), .rst_i(Reset), .frame_en_i(frame_en), .clr_i(tmr_clr),
    .load_i(hit2), .code_i(code1), .dir_i(BallX_p1 >= BallX_p2),
    .back_o(back1_c), .stand_left_o(stand_left1), .stand_right_o(stand_right1),
    .busy_o(busy1)
  );

  knock_timer #(.KNOCK_LEN(KNOCK_FRAMES), .BLOCK_LEN(BLOCK_FRAMES)) u_tmr2 (
    .clk_i(Clk), .rst_i(Reset), .frame_en_i(frame_en), .clr_i(tmr_clr),
    .load_i(hit1), .code_i(code2), .dir_i(BallX_p2 >= BallX_p1),
    .back_o(back2_c), .stand_left_o(stand_left2), .stand_right_o(stand_right2),
    .busy_o(busy2)
  );

  assign back1 = back1_c;
  assign back2 = back2_c;
  assign hp1   = hp1_q;
  assign hp2   = hp2_q;
  assign p1win = p1win_q;
  assign p2win = p2win_q;

endmodule

// File: tb/tb_combat_referee.sv
module tb_combat_referee;

  logic       Clk = 1'b0;
  logic       Reset, frame_en, start;
  logic       kick_p1, fight_p1, dodge_p1, kick_p2, fight_p2, dodge_p2;
  logic [9:0] BallX_p1, BallX_p2;
  logic       near_y;
  logic [1:0] back1, back2;
  logic       stand_left1, stand_right1, stand_left2, stand_right2;
  logic [6:0] hp1, hp2;
  logic       p1win, p2win;

  int checks = 0;
  int failures = 0;

  combat_referee dut (
    .Clk(Clk), .Reset(Reset), .frame_en(frame_en), .start(start),
    .kick_p1(kick_p1), .fight_p1(fight_p1), .dodge_p1(dodge_p1),
    .kick_p2(kick_p2), .fight_p2(fight_p2), .dodge_p2(dodge_p2),
    .BallX_p1(BallX_p1), .BallX_p2(BallX_p2), .near_y(near_y),
    .back1(back1), .back2(back2),
    .stand_left1(stand_left1), .stand_right1(stand_right1),
    .stand_left2(stand_left2), .stand_right2(stand_right2),
    .hp1(hp1), .hp2(hp2), .p1win(p1win), .p2win(p2win)
  );

  always #5 Clk = ~Clk;

  // Inputs are set before the call; one frame strobe, outputs sampled on a negedge.
  task automatic frame();
    @(negedge Clk) frame_en = 1'b1;
    @(negedge Clk) frame_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_en = 1'b0; start = 1'b0;
    kick_p1 = 0; fight_p1 = 0; dodge_p1 = 0; kick_p2 = 0; fight_p2 = 0; dodge_p2 = 0;
    BallX_p1 = 10'd100; BallX_p2 = 10'd140; near_y = 1'b1;
    @(negedge Clk);
    @(negedge Clk) Reset = 1'b0;
  endtask

  // Reset, then one frame with start=1 to enter FIGHT.
  task automatic begin_fight();
    do_reset();
    start = 1'b1;
    frame();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (hp1 !== 7'd100 || hp2 !== 7'd100) begin
      $display("FAIL reset_hp got hp1=%0d hp2=%0d exp 100/100", hp1, hp2); failures++;
    end
    checks++;
    if (back1 !== 2'd0 || back2 !== 2'd0 || p1win !== 1'b0 || p2win !== 1'b0) begin
      $display("FAIL reset_flags got back1=%0d back2=%0d p1win=%0b p2win=%0b exp all 0",
               back1, back2, p1win, p2win); failures++;
    end
    checks++;
    if ({stand_left1, stand_right1, stand_left2, stand_right2} !== 4'b0) begin
      $display("FAIL reset_stand got %b exp 0000",
               {stand_left1, stand_right1, stand_left2, stand_right2}); failures++;
    end
    // IDLE judges nothing even with an in-range attack.
    kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd100 || back2 !== 2'd0) begin
      $display("FAIL idle_no_hit got hp2=%0d back2=%0d exp 100/0", hp2, back2); failures++;
    end
  endtask

  task automatic test_clean_hit();
    int n_back, n_right;
    begin_fight();
    kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd85 || back2 !== 2'd2) begin
      $display("FAIL clean_hit got hp2=%0d back2=%0d exp 85/2", hp2, back2); failures++;
    end
    checks++;
    if (stand_right2 !== 1'b1 || stand_left2 !== 1'b0 || hp1 !== 7'd100 || back1 !== 2'd0) begin
      $display("FAIL clean_side got sr2=%0b sl2=%0b hp1=%0d back1=%0d exp 1/0/100/0",
               stand_right2, stand_left2, hp1, back1); failures++;
    end
    n_back = 0; n_right = 0;
    for (int i = 0; i < 20; i++) begin
      if (back2 == 2'd2) n_back++;
      if (stand_right2 == 1'b1) n_right++;
      frame();   // kick held throughout
    end
    checks++;
    if (n_back != 12 || n_right != 12) begin
      $display("FAIL knock_len got back=%0d right=%0d frames exp 12/12", n_back, n_right); failures++;
    end
    checks++;
    if (hp2 !== 7'd85) begin
      $display("FAIL hold_no_rehit got hp2=%0d exp 85", hp2); failures++;
    end
  endtask

  task automatic test_block();
    int n_back;
    begin_fight();
    dodge_p2 = 1'b1; kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd100 || back2 !== 2'd1 || stand_right2 !== 1'b1) begin
      $display("FAIL block got hp2=%0d back2=%0d sr2=%0b exp 100/1/1", hp2, back2, stand_right2);
      failures++;
    end
    n_back = 0;
    for (int i = 0; i < 12; i++) begin
      if (back2 == 2'd1) n_back++;
      frame();
    end
    checks++;
    if (n_back != 6 || back2 !== 2'd0) begin
      $display("FAIL block_len got frames=%0d back2=%0d exp 6/0", n_back, back2); failures++;
    end
  endtask

  task automatic test_trade();
    begin_fight();
    kick_p1 = 1'b1; fight_p2 = 1'b1; frame();
    checks++;
    if (hp1 !== 7'd90 || hp2 !== 7'd85) begin
      $display("FAIL trade_hp got hp1=%0d hp2=%0d exp 90/85", hp1, hp2); failures++;
    end
    checks++;
    if (back1 !== 2'd2 || back2 !== 2'd2 || stand_left1 !== 1'b1 || stand_right1 !== 1'b0) begin
      $display("FAIL trade_back got back1=%0d back2=%0d sl1=%0b sr1=%0b exp 2/2/1/0",
               back1, back2, stand_left1, stand_right1); failures++;
    end
  endtask

  task automatic test_range();
    begin_fight();
    BallX_p2 = 10'd161; kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd100 || back2 !== 2'd0) begin
      $display("FAIL range_61 got hp2=%0d back2=%0d exp 100/0", hp2, back2); failures++;
    end
    kick_p1 = 1'b0; frame();
    BallX_p2 = 10'd140; near_y = 1'b0; kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd100 || back2 !== 2'd0) begin
      $display("FAIL near_y_0 got hp2=%0d back2=%0d exp 100/0", hp2, back2); failures++;
    end
    kick_p1 = 1'b0; frame();
    BallX_p2 = 10'd160; near_y = 1'b1; kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd85 || back2 !== 2'd2) begin
      $display("FAIL range_60 got hp2=%0d back2=%0d exp 85/2", hp2, back2); failures++;
    end
    kick_p1 = 1'b0; frame();
    kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd85) begin
      $display("FAIL invuln got hp2=%0d exp 85", hp2); failures++;
    end
    // Reversed positions: victim left of attacker is pushed left.
    for (int i = 0; i < 12; i++) begin kick_p1 = 1'b0; frame(); end
    BallX_p1 = 10'd300; BallX_p2 = 10'd250; fight_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd75 || stand_left2 !== 1'b1 || stand_right2 !== 1'b0) begin
      $display("FAIL push_left got hp2=%0d sl2=%0b sr2=%0b exp 75/1/0",
               hp2, stand_left2, stand_right2); failures++;
    end
  endtask

  task automatic test_ko();
    begin_fight();
    for (int k = 1; k <= 6; k++) begin
      kick_p1 = 1'b1; frame();
      for (int i = 0; i < 12; i++) begin kick_p1 = 1'b0; frame(); end
    end
    checks++;
    if (hp2 !== 7'd10 || back2 !== 2'd0) begin
      $display("FAIL ko_setup got hp2=%0d back2=%0d exp 10/0", hp2, back2); failures++;
    end
    fight_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd0 || p1win !== 1'b1 || p2win !== 1'b0) begin
      $display("FAIL ko got hp2=%0d p1win=%0b p2win=%0b exp 0/1/0", hp2, p1win, p2win); failures++;
    end
    fight_p1 = 1'b0; frame();
    checks++;
    if (back1 !== 2'd0 || back2 !== 2'd0) begin
      $display("FAIL over_back got back1=%0d back2=%0d exp 0/0", back1, back2); failures++;
    end
    kick_p1 = 1'b1; kick_p2 = 1'b1; frame();
    checks++;
    if (hp1 !== 7'd100 || back1 !== 2'd0 || back2 !== 2'd0 || p1win !== 1'b1 || p2win !== 1'b0) begin
      $display("FAIL over_ignore got hp1=%0d back1=%0d back2=%0d p1win=%0b p2win=%0b exp 100/0/0/1/0",
               hp1, back1, back2, p1win, p2win); failures++;
    end
  endtask

  task automatic test_reset_mid();
    begin_fight();
    kick_p1 = 1'b1; frame();
    kick_p1 = 1'b0; frame(); frame();
    // Frame strobe held low: nothing may move however the inputs wiggle.
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      kick_p2 = i[0]; fight_p1 = i[1]; start = ~i[0];
    end
    checks++;
    if (hp2 !== 7'd85 || back2 !== 2'd2 || hp1 !== 7'd100 || back1 !== 2'd0) begin
      $display("FAIL no_frame_en got hp2=%0d back2=%0d hp1=%0d back1=%0d exp 85/2/100/0",
               hp2, back2, hp1, back1); failures++;
    end
    kick_p2 = 1'b0; fight_p1 = 1'b0; start = 1'b0;
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    checks++;
    if (hp2 !== 7'd100 || back2 !== 2'd0 || stand_right2 !== 1'b0) begin
      $display("FAIL reset_mid got hp2=%0d back2=%0d sr2=%0b exp 100/0/0", hp2, back2, stand_right2);
      failures++;
    end
    // Back in IDLE: an attack without start must not land.
    kick_p1 = 1'b1; frame();
    checks++;
    if (hp2 !== 7'd100 || back2 !== 2'd0) begin
      $display("FAIL reset_idle got hp2=%0d back2=%0d exp 100/0", hp2, back2); failures++;
    end
  endtask

  initial begin
    Reset = 1'b1; frame_en = 1'b0; start = 1'b0;
    kick_p1 = 0; fight_p1 = 0; dodge_p1 = 0; kick_p2 = 0; fight_p2 = 0; dodge_p2 = 0;
    BallX_p1 = 10'd100; BallX_p2 = 10'd140; near_y = 1'b1;
    test_reset();
    test_clean_hit();
    test_block();
    test_trade();
    test_range();
    test_ko();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
